// File: rtl/key_recorder.sv
// key_recorder: record/playback engine for the FPGA piano.
// Watches debounced key switches, records each note or rest with its duration
// (in ticks of TICK_DIV clocks) into an internal buffer, and replays it as the
// note index driven to the tone divider. Live keys pass through when not playing.
//
// Ports:
//   CLK        system clock
//   RESET      asynchronous active-low reset
//   sw         debounced key levels, bit N_KEYS-1 has highest priority
//   rec_btn    pulse: start recording (clears the buffer)
//   play_btn   pulse: start playback (ignored when the buffer is empty)
//   stop_btn   pulse: stop record/playback (beats rec_btn, which beats play_btn)
//   note_valid 1 = a note sounds, 0 = rest
//   note_idx   index of the sounding key
//   mode       0 IDLE, 1 REC, 2 PLAY
//   count      stored entries
//   full       buffer filled during the last recording
//
// Optional feature: define LOOP_PLAYBACK_EN to repeat playback from entry 0
// without a gap until stop_btn; otherwise playback is a single pass.
module key_recorder #(
  parameter int unsigned N_KEYS   = 8,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned DUR_W    = 12,
  parameter int unsigned TICK_DIV = 100000,
  localparam int unsigned IDX_W   = (N_KEYS > 1) ? $clog2(N_KEYS) : 1,
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [N_KEYS-1:0] sw,
  input  logic              rec_btn,
  input  logic              play_btn,
  input  logic              stop_btn,
  output logic              note_valid,
  output logic [IDX_W-1:0]  note_idx,
  output logic [1:0]        mode,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [DUR_W-1:0] dur;
  } entry_t;

  state_t             state;
  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic               ev_valid;
  logic [IDX_W-1:0]   ev_idx;
  logic               open;
  logic               cur_valid;
  logic [IDX_W-1:0]   cur_idx;
  logic [DUR_W-1:0]   dur;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [DUR_W-1:0]   pl_dur;
  logic               wr_en;
  entry_t             wr_entry;
  entry_t             rd_entry;
  entry_t             nxt_entry;
  entry_t             first_entry;
  logic               last_entry;
  logic               commit_fills;

  entry_t mem [DEPTH];

  assign mode = state;
  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  // Priority resolve: highest set switch wins; no switch means rest (idx 0).
  always_comb begin
    ev_valid = 1'b0;
    ev_idx   = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (sw[i]) begin
        ev_valid = 1'b1;
        ev_idx   = IDX_W'(i);
      end
    end
  end

  // Commit decision for the open recording event.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = '{valid: cur_valid, idx: cur_idx, dur: dur};
    if (state == ST_REC && open) begin
      if (stop_btn)
        wr_en = !full;
      else if (ev_valid != cur_valid || ev_idx != cur_idx)
        wr_en = 1'b1;
      else if (tick && dur == DUR_MAX)
        wr_en = 1'b1;
    end
  end

  assign commit_fills = ((count + CNT_W'(1)) == CNT_W'(DEPTH));
  assign rd_entry     = mem[rd_ptr];
  assign nxt_entry    = mem[rd_ptr + ADDR_W'(1)];
  assign first_entry  = mem[0];
  assign last_entry   = (rd_ptr == ADDR_W'(count - CNT_W'(1)));

  // Event buffer; contents need no reset.
  always_ff @(posedge CLK) begin
    if (wr_en)
      mem[ADDR_W'(count)] <= wr_entry;
  end

  // Mode FSM, tick counter, recording and playback state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      note_valid <= 1'b0;
      note_idx   <= '0;
      count      <= '0;
      full       <= 1'b0;
      tick_cnt   <= '0;
      open       <= 1'b0;
      cur_valid  <= 1'b0;
      cur_idx    <= '0;
      dur        <= '0;
      rd_ptr     <= '0;
      pl_dur     <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
      case (state)
        ST_IDLE: begin
          note_valid <= ev_valid;
          note_idx   <= ev_idx;
          if (stop_btn) begin
            state <= ST_IDLE;
          end else if (rec_btn) begin
            state    <= ST_REC;
            count    <= '0;
            full     <= 1'b0;
            open     <= 1'b0;
            tick_cnt <= '0;
          end else if (play_btn && count != '0) begin
            state      <= ST_PLAY;
            rd_ptr     <= '0;
            pl_dur     <= DUR_W'(1);
            note_valid <= first_entry.valid;
            note_idx   <= first_entry.idx;
            tick_cnt   <= '0;
          end
        end

        ST_REC: begin
          note_valid <= ev_valid;
          note_idx   <= ev_idx;
          if (stop_btn) begin
            if (wr_en)
              count <= count + CNT_W'(1);
            open     <= 1'b0;
            state    <= ST_IDLE;
            tick_cnt <= '0;
          end else if (!open) begin
            // Leading rests are skipped until the first note.
            if (ev_valid) begin
              open      <= 1'b1;
              cur_valid <= ev_valid;
              cur_idx   <= ev_idx;
              dur       <= DUR_W'(1);
            end
          end else if (wr_en) begin
            count <= count + CNT_W'(1);
            if (commit_fills) begin
              full     <= 1'b1;
              open     <= 1'b0;
              state    <= ST_IDLE;
              tick_cnt <= '0;
            end else begin
              // Reopen with the current event (same one on saturation).
              cur_valid <= ev_valid;
              cur_idx   <= ev_idx;
              dur       <= DUR_W'(1);
            end
          end else if (tick) begin
            dur <= dur + DUR_W'(1);
          end
        end

        ST_PLAY: begin
          if (stop_btn) begin
            note_valid <= 1'b0;
            state      <= ST_IDLE;
            tick_cnt   <= '0;
          end else if (tick) begin
            if (pl_dur >= rd_entry.dur) begin
              if (last_entry) begin
`ifdef LOOP_PLAYBACK_EN
                rd_ptr     <= '0;
                pl_dur     <= DUR_W'(1);
                note_valid <= first_entry.valid;
                note_idx   <= first_entry.idx;
`else
                note_valid <= 1'b0;
                state      <= ST_IDLE;
                tick_cnt   <= '0;
`endif
              end else begin
                rd_ptr     <= rd_ptr + ADDR_W'(1);
                pl_dur     <= DUR_W'(1);
                note_valid <= nxt_entry.valid;
                note_idx   <= nxt_entry.idx;
              end
            end else begin
              pl_dur <= pl_dur + DUR_W'(1);
            end
          end
        end

        default: begin
          state      <= ST_IDLE;
          note_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_recorder.sv
// Directed bench for key_recorder: main instance (TICK_DIV=4), a DEPTH=4
// instance for the full condition and a DUR_W=2 instance for saturation.
module tb_key_recorder;

  logic       CLK;
  logic       RESET;

  logic [7:0] sw_a, sw_b, sw_c;
  logic       rec_a, play_a, stop_a;
  logic       rec_b, play_b, stop_b;
  logic       rec_c, play_c, stop_c;

  logic       nv_a, nv_b, nv_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic [1:0] mode_a, mode_b, mode_c;
  logic [5:0] count_a, count_c;
  logic [2:0] count_b;
  logic       full_a, full_b, full_c;

  int checks = 0;
  int errors = 0;

  key_recorder #(.N_KEYS(8), .DEPTH(32), .DUR_W(12), .TICK_DIV(4)) u_a (
    .CLK(CLK), .RESET(RESET), .sw(sw_a), .rec_btn(rec_a), .play_btn(play_a),
    .stop_btn(stop_a), .note_valid(nv_a), .note_idx(idx_a), .mode(mode_a),
    .count(count_a), .full(full_a));

  key_recorder #(.N_KEYS(8), .DEPTH(4), .DUR_W(12), .TICK_DIV(4)) u_b (
    .CLK(CLK), .RESET(RESET), .sw(sw_b), .rec_btn(rec_b), .play_btn(play_b),
    .stop_btn(stop_b), .note_valid(nv_b), .note_idx(idx_b), .mode(mode_b),
    .count(count_b), .full(full_b));

  key_recorder #(.N_KEYS(8), .DEPTH(32), .DUR_W(2), .TICK_DIV(4)) u_c (
    .CLK(CLK), .RESET(RESET), .sw(sw_c), .rec_btn(rec_c), .play_btn(play_c),
    .stop_btn(stop_c), .note_valid(nv_c), .note_idx(idx_c), .mode(mode_c),
    .count(count_c), .full(full_c));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Expected {mode, note_valid, idx-if-valid} k cycles after play_btn.
  // Entries {1,5,4}, {0,-,3}, {1,3,3} at 4 clocks per tick.
  function automatic logic [5:0] play_exp(input int k);
    if (k < 16) return {2'd2, 1'b1, 3'd5};
    if (k < 28) return {2'd2, 1'b0, 3'd0};
    if (k < 40) return {2'd2, 1'b1, 3'd3};
`ifdef LOOP_PLAYBACK_EN
    if (k < 56) return {2'd2, 1'b1, 3'd5};
    return {2'd2, 1'b0, 3'd0};
`else
    return {2'd0, 1'b0, 3'd0};
`endif
  endfunction

`ifdef LOOP_PLAYBACK_EN
  localparam int PLAY_LAST = 44;
`else
  localparam int PLAY_LAST = 40;
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0;
    sw_a = '0; sw_b = '0; sw_c = '0;
    rec_a = 0; play_a = 0; stop_a = 0;
    rec_b = 0; play_b = 0; stop_b = 0;
    rec_c = 0; play_c = 0; stop_c = 0;
    cycles(3);
    check("rst_mode", mode_a, 0);
    check("rst_nv", nv_a, 0);
    check("rst_idx", idx_a, 0);
    check("rst_count", count_a, 0);
    check("rst_full", full_a, 0);
    RESET = 1'b1;
    cycles(2);

    // play with an empty buffer is ignored
    play_a = 1; cycles(1); play_a = 0;
    check("play_empty_mode", mode_a, 0);
    cycles(1);
    check("play_empty_mode2", mode_a, 0);

    // live pass-through
    sw_a = 8'b0010_1000; cycles(1);
    check("live_nv", nv_a, 1);
    check("live_idx", idx_a, 5);
    sw_a = 8'h00; cycles(1);
    check("live_rest", nv_a, 0);

    // record: 20 rest, 12 key5, 8 rest, 8 key3, stop
    rec_a = 1; cycles(1); rec_a = 0;
    check("rec_mode", mode_a, 1);
    check("rec_count0", count_a, 0);
    sw_a = 8'h00; cycles(20);
    check("rec_lead_rest_count", count_a, 0);
    sw_a = 8'h20; cycles(12);
    check("rec_live_idx", idx_a, 5);
    sw_a = 8'h00; cycles(8);
    check("rec_count1", count_a, 1);
    sw_a = 8'h08; cycles(8);
    check("rec_count2", count_a, 2);
    sw_a = 8'h00; play_a = 1; stop_a = 1; cycles(1); stop_a = 0; play_a = 0;
    check("rec_stop_count", count_a, 3);
    check("rec_stop_mode", mode_a, 0);
    check("rec_stop_full", full_a, 0);
    cycles(2);

    // playback
    play_a = 1; cycles(1); play_a = 0;
    for (int k = 0; k <= PLAY_LAST; k++) begin
      check($sformatf("play_c%0d", k),
            {26'd0, mode_a, nv_a, (nv_a ? idx_a : 3'd0)}, {26'd0, play_exp(k)});
      if (k < PLAY_LAST) cycles(1);
    end
    check("play_count_kept", count_a, 3);

`ifndef LOOP_PLAYBACK_EN
    play_a = 1; cycles(1); play_a = 0;
    check("replay_mode", mode_a, 2);
    cycles(5);
`endif
    // stop beats rec during playback
    stop_a = 1; rec_a = 1; cycles(1); stop_a = 0; rec_a = 0;
    check("stoprec_mode", mode_a, 0);
    check("stoprec_nv", nv_a, 0);
    check("stoprec_count", count_a, 3);
    cycles(1);
    check("stoprec_mode2", mode_a, 0);

    // full: DEPTH=4, alternate key0/key1 every 8 cycles
    rec_b = 1; cycles(1); rec_b = 0;
    sw_b = 8'h01; cycles(8);
    sw_b = 8'h02; cycles(8);
    sw_b = 8'h01; cycles(8);
    sw_b = 8'h02; cycles(8);
    check("full_pre_count", count_b, 3);
    check("full_pre_mode", mode_b, 1);
    check("full_pre_full", full_b, 0);
    sw_b = 8'h01; cycles(1);
    check("full_count", count_b, 4);
    check("full_flag", full_b, 1);
    check("full_mode", mode_b, 0);
    sw_b = 8'h02; cycles(8);
    sw_b = 8'h01; cycles(8);
    check("full_hold_count", count_b, 4);
    check("full_hold_mode", mode_b, 0);

    // saturation: DUR_W=2, key0 held 24 cycles -> durs 3,3,1
    rec_c = 1; cycles(1); rec_c = 0;
    sw_c = 8'h01; cycles(24);
    check("sat_count_mid", count_c, 2);
    stop_c = 1; cycles(1); stop_c = 0;
    sw_c = 8'h00;
    check("sat_count", count_c, 3);
    cycles(2);
    play_c = 1; cycles(1); play_c = 0;
    check("sat_play_start", {mode_c, nv_c, idx_c}, {2'd2, 1'b1, 3'd0});
    cycles(27);
    check("sat_play_end_m1", {mode_c, nv_c}, {2'd2, 1'b1});
    cycles(1);
`ifdef LOOP_PLAYBACK_EN
    check("sat_play_loop", {mode_c, nv_c}, {2'd2, 1'b1});
    stop_c = 1; cycles(1); stop_c = 0;
`endif
    check("sat_play_end", {mode_c, nv_c}, {2'd0, 1'b0});

    // asynchronous reset in the middle of playback
    play_a = 1; cycles(1); play_a = 0;
    cycles(5);
    check("prereset_mode", mode_a, 2);
    #2 RESET = 1'b0;
    #1;
    check("areset_mode", mode_a, 0);
    check("areset_nv", nv_a, 0);
    check("areset_count", count_a, 0);
    check("areset_full", full_b, 0);
    cycles(1);
    RESET = 1'b1;
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
